// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_mp_sb_pkg;

  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefDataWidth = 32;
  // busy_cnt has to hold the full depth, hence one bit wider than an index.
  localparam int unsigned DefCntWidth  = DefAddrWidth + 1;

  // Low bit of port idx inside a packed bus of width-wide slices.
  function automatic int unsigned slice_lo(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write and reservation signals between issue/writeback and the register file.
interface regfile_mp_sb_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned NWRITE     = 2
) ();

  logic [NREAD*ADDR_WIDTH-1:0]  rd_addr;
  logic [NREAD*DATA_WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]             rd_busy;
  logic [NWRITE-1:0]            wr_en;
  logic [NWRITE*ADDR_WIDTH-1:0] wr_addr;
  logic [NWRITE*DATA_WIDTH-1:0] wr_data;
  logic                         rsv_en;
  logic [ADDR_WIDTH-1:0]        rsv_addr;
  logic                         rsv_ok;
  logic [ADDR_WIDTH:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_cnt
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy flags: set by accepted reservations, cleared by writeback.
module regfile_mp_sb_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NWRITE     = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  // Enables arrive already stripped of writes to the hardwired zero register.
  input  logic [NWRITE-1:0]            wr_en,
  input  logic [NWRITE*ADDR_WIDTH-1:0] wr_addr,
  output logic                         rsv_ok,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [DEPTH-1:0]     busy_q, busy_d, set_mask, clr_mask;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, n_released;
  logic                 rsv_zero;

  // Reservation acceptance, release mask and the resulting counter delta.
  always_comb begin
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    rsv_ok   = rsv_en & (rsv_zero | ~busy_q[rsv_addr]);

    set_mask = '0;
    if (rsv_ok && !rsv_zero) begin
      set_mask[rsv_addr] = 1'b1;
    end

    clr_mask = '0;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j]) begin
        clr_mask[wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
      end
    end

    // An accepted reservation only targets an idle register, so counting
    // busy & clr gives exactly the distinct 1->0 transitions.
    n_released = '0;
    for (int k = 0; k < DEPTH; k++) begin
      n_released = n_released + CNT_WIDTH'(busy_q[k] & clr_mask[k]);
    end

    // Set after clear: a reservation beats a same-cycle release.
    busy_d = (busy_q & ~clr_mask) | set_mask;
    cnt_d  = cnt_q + CNT_WIDTH'(set_mask != '0) - n_released;
  end

  // Busy flags and counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass, zero register and busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned NWRITE     = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q      [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr_a [NWRITE];
  logic [DATA_WIDTH-1:0] wr_data_a [NWRITE];
  logic [NWRITE-1:0]     wr_en_f;
  logic [ADDR_WIDTH-1:0] rd_addr_a [NREAD];
  logic [DATA_WIDTH-1:0] rd_val    [NREAD];
  logic [DEPTH-1:0]      busy;

  // Unpack write ports and drop writes aimed at the hardwired zero register.
  always_comb begin
    for (int j = 0; j < NWRITE; j++) begin
      wr_addr_a[j] = bus.wr_addr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
      wr_data_a[j] = bus.wr_data[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
      wr_en_f[j]   = bus.wr_en[j] & ~((ZERO_REG != 0) && (wr_addr_a[j] == '0));
    end
  end

  // Data array; later ports are applied last so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf_q[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en_f[j]) begin
          rf_q[wr_addr_a[j]] <= wr_data_a[j];
        end
      end
    end
  end

  // Zero-latency reads with optional forwarding of this cycle's write data.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr_a[i] = bus.rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
      rd_val[i]    = rf_q[rd_addr_a[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_en_f[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
            rd_val[i] = wr_data_a[j];
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr_a[i] == '0)) begin
        rd_val[i] = '0;
      end
      bus.rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rd_val[i];
      bus.rd_busy[i] = busy[rd_addr_a[i]];
    end
  end

  regfile_mp_sb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NWRITE     (NWRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (wr_en_f),
    .wr_addr  (bus.wr_addr),
    .rsv_ok   (bus.rsv_ok),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined NPC core. It replaces the single-write, two-read register file and adds the following:
- configurable read and write port counts
- optional same-cycle write-to-read bypass
- optional hardwired zero register
- a per-register busy scoreboard, reserved at issue and released at writeback

It sits between decode/issue (reads, reservations) and writeback (writes, releases).

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes busy
BYPASS, 1, 1 = read of an address written this cycle returns the write data

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
rd_addr  in  NREAD*ADDR_WIDTH  packed read addresses; port i at slice i
rd_data  out  NREAD*DATA_WIDTH  packed read data, combinational
rd_busy  out  NREAD  busy bit of each read address, pre-edge state
wr_en  in  NWRITE  write enables
wr_addr  in  NWRITE*ADDR_WIDTH  packed write addresses
wr_data  in  NWRITE*DATA_WIDTH  packed write data
rsv_en  in  1  reserve request for rsv_addr (issue of an instruction writing rsv_addr)
rsv_addr  in  ADDR_WIDTH  register to reserve
rsv_ok  out  1  combinational; reservation accepted this cycle
busy_cnt  out  ADDR_WIDTH+1  number of currently busy registers

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst is synchronous, active-high.
  - While rst=1 at a posedge: all registers go to 0, all busy bits go to 0, busy_cnt goes to 0.
  - Writes and reservations presented in that cycle are discarded.
- Output values during and after reset:
  - rd_data is combinational from state, so it reads 0 after reset.
  - rd_busy = 0, rsv_ok as defined below, busy_cnt = 0.
- Write:
  - At posedge, for each port j with wr_en[j]=1, rf[wr_addr_j] <= wr_data_j.
  - Same address on both ports: the higher-indexed port wins.
  - With ZERO_REG=1, any write to address 0 is dropped.
- Read:
  - Zero latency: rd_data_i = rf[rd_addr_i].
  - With ZERO_REG=1, address 0 returns 0 regardless of bypass.
  - With BYPASS=1, if any enabled write port targets rd_addr_i this cycle, rd_data_i = that port's wr_data. When several ports match, the highest index wins, consistent with the write rule.
- Scoreboard release:
  - Any enabled write (post zero-filter) to address a clears busy[a] at the edge.
- Scoreboard reserve:
  - rsv_ok = rsv_en & ~busy[rsv_addr] (pre-edge).
  - With ZERO_REG=1 and rsv_addr=0: rsv_ok = rsv_en and no busy bit is set.
  - If rsv_ok, busy[rsv_addr] <= 1 at the edge.
  - A rejected reservation (WAW on a busy register) changes nothing; issue must stall and retry.
- Simultaneous reserve and write, same address a:
  - busy[a]=1 pre-edge: rsv_ok=0. The write releases the register; the reservation succeeds the next cycle.
  - busy[a]=0 pre-edge: rsv_ok=1. The write lands and busy[a] ends at 1 (reservation wins over release).
- busy_cnt:
  - Updated at the edge: +1 for an accepted reservation, −1 for each distinct address actually transitioning busy 1→0.
  - Net change is in −2..+1.
  - Never wraps: maximum is 2**ADDR_WIDTH (or −1 with ZERO_REG), minimum 0.
- rd_busy_i reflects pre-edge busy[rd_addr_i]; it is always 0 for address 0 when ZERO_REG=1.
- No other state; no state machine beyond per-register busy flags and the counter.

Decomposition:
- Package rf_pkg: ADDR_WIDTH/DATA_WIDTH defaults, a packed-slice helper function for port indexing, and the busy_cnt width constant.
- Sub-module rf_scoreboard holds the busy bits, reserve/release logic and busy_cnt. Its inputs are clk, rst, rsv_en/addr and the filtered write enables/addresses; its outputs are rsv_ok, the busy vector and busy_cnt.
- The data array, bypass and write-priority muxes stay in the top level.

Test Plan:
- Reset, then read all addresses on both read ports: rd_data=0, rd_busy=0, busy_cnt=0. Write x0=0xDEADBEEF on port0, then read x0: 0.
- Port0 writes x5=0x11, port1 writes x5=0x22 in the same cycle, with read port0 on x5 and BYPASS=1: rd_data0=0x22 in that cycle; x5=0x22 next cycle. Repeat with BYPASS=0: rd_data0 = old value (0), then 0x22.
- Reserve x7: rsv_ok=1, busy_cnt 0→1. Reserve x7 again: rsv_ok=0, busy_cnt stays 1. Write x7=0x33: busy[7] cleared, busy_cnt=0.
- Same cycle, x9 busy: reserve x9 plus write x9=0x44 gives rsv_ok=0, busy[9]=0 after the edge, x9=0x44. Same cycle, x9 idle: rsv_ok=1, busy[9]=1 after the edge, x9=0x44, busy_cnt +1.
- Reserve x3, x4 over two cycles (busy_cnt=2). Then port0 writes x3 and port1 writes x4 in the same cycle while x6 is reserved: busy_cnt 2→1, with x6 busy only.
- Reserve x10 and write x11=0x55, then assert rst for one cycle while a write x12=0x66 and a reserve of x13 are presented: afterwards all data=0, busy_cnt=0, x12=0, x13 not busy.
